// File: rtl/vga_pkg.sv
// Shared constants and state type for the vblank write arbiter.
package vga_pkg;

    localparam int ARB_N_REQ  = 4;
    localparam int ARB_ADDR_W = 8;
    localparam int ARB_DATA_W = 24;
    localparam int ARB_MAX_WR = 16;

    typedef enum logic [1:0] {
        ACTIVE = 2'd0,
        OPEN   = 2'd1,
        LOCKED = 2'd2
    } arb_state_t;

endpackage

// File: rtl/vblnk_write_arbiter_if.sv
// Requester/register-file bundle around the vblank write arbiter.
interface vblnk_write_arbiter_if
    import vga_pkg::*;
#(
    parameter int N_REQ  = ARB_N_REQ,
    parameter int ADDR_W = ARB_ADDR_W,
    parameter int DATA_W = ARB_DATA_W
) ();

    logic                       vblnk;
    logic [N_REQ-1:0]           req;
    logic [N_REQ*ADDR_W-1:0]    req_addr;
    logic [N_REQ*DATA_W-1:0]    req_data;
    logic [N_REQ-1:0]           gnt;
    logic                       wr_en;
    logic [ADDR_W-1:0]          wr_addr;
    logic [DATA_W-1:0]          wr_data;
    logic                       frame_tick;
    logic [N_REQ-1:0]           miss;

    modport master (
        output vblnk, req, req_addr, req_data,
        input  gnt, wr_en, wr_addr, wr_data, frame_tick, miss
    );

    modport slave (
        input  vblnk, req, req_addr, req_data,
        output gnt, wr_en, wr_addr, wr_data, frame_tick, miss
    );

endinterface

// File: rtl/rr_pick.sv
// Combinational round-robin pick: first eligible requester after last.
module rr_pick #(
    parameter int N_REQ = 4
) (
    input  logic [N_REQ-1:0]         i_elig,
    input  logic [$clog2(N_REQ)-1:0] i_last,
    output logic [N_REQ-1:0]         o_win,
    output logic                     o_vld
);

    localparam int IDX_W = $clog2(N_REQ);

    logic [IDX_W-1:0] w_sel;

    always_comb begin
        o_win = '0;
        o_vld = 1'b0;
        w_sel = '0;
        for (int k = 0; k < N_REQ; k++) begin
            w_sel = IDX_W'((int'(i_last) + 1 + k) % N_REQ);
            if (!o_vld && i_elig[w_sel]) begin
                o_win[w_sel] = 1'b1;
                o_vld        = 1'b1;
            end
        end
    end

endmodule

// File: rtl/vblnk_write_arbiter.sv
// Round-robin write arbiter into the display parameter register file,
// granting only inside vertical blanking and at most MAX_WR times per frame.
module vblnk_write_arbiter
    import vga_pkg::*;
#(
    parameter int N_REQ  = ARB_N_REQ,
    parameter int ADDR_W = ARB_ADDR_W,
    parameter int DATA_W = ARB_DATA_W,
    parameter int MAX_WR = ARB_MAX_WR
) (
    input logic                  clk,
    input logic                  rst,
    vblnk_write_arbiter_if.slave bus
);

    localparam int               CNT_W   = $clog2(MAX_WR + 1);
    localparam int               IDX_W   = $clog2(N_REQ);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MAX_WR);

    arb_state_t       r_state;
    arb_state_t       w_state_nxt;
    logic [CNT_W-1:0] r_cnt;
    logic [IDX_W-1:0] r_last;
    logic [N_REQ-1:0] r_gnt;
    logic [N_REQ-1:0] r_miss;
    logic             r_wr_en;
    logic             r_frame_tick;
    logic [ADDR_W-1:0] r_wr_addr;
    logic [DATA_W-1:0] r_wr_data;

    logic [N_REQ-1:0]  w_elig;
    logic [N_REQ-1:0]  w_win;
    logic              w_win_vld;
    logic [IDX_W-1:0]  w_win_idx;
    logic [ADDR_W-1:0] w_addr;
    logic [DATA_W-1:0] w_data;
    logic              w_grant;
    logic              w_open_edge;
    logic              w_close_edge;

    // The requester acknowledged this cycle is masked so a held req
    // cannot be granted twice.
    assign w_elig = bus.req & ~r_gnt;

    rr_pick #(.N_REQ(N_REQ)) u_pick (
        .i_elig (w_elig),
        .i_last (r_last),
        .o_win  (w_win),
        .o_vld  (w_win_vld)
    );

    always_comb begin
        w_win_idx = '0;
        w_addr    = '0;
        w_data    = '0;
        for (int i = 0; i < N_REQ; i++) begin
            if (w_win[i]) begin
                w_win_idx = IDX_W'(i);
                w_addr    = bus.req_addr[i*ADDR_W +: ADDR_W];
                w_data    = bus.req_data[i*DATA_W +: DATA_W];
            end
        end
    end

    assign w_grant = (r_state == OPEN) && bus.vblnk
                  && (r_cnt < CNT_MAX) && w_win_vld;

    assign w_open_edge  = (r_state == ACTIVE) && bus.vblnk;
    assign w_close_edge = (r_state != ACTIVE) && !bus.vblnk;

    always_comb begin
        w_state_nxt = r_state;
        unique case (r_state)
            ACTIVE: begin
                if (bus.vblnk) w_state_nxt = OPEN;
            end
            OPEN: begin
                if (!bus.vblnk)
                    w_state_nxt = ACTIVE;
                else if (w_grant && (r_cnt == CNT_MAX - CNT_W'(1)))
                    w_state_nxt = LOCKED;
            end
            LOCKED: begin
                if (!bus.vblnk) w_state_nxt = ACTIVE;
            end
            default: w_state_nxt = ACTIVE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) r_state <= ACTIVE;
        else     r_state <= w_state_nxt;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt        <= '0;
            r_last       <= IDX_W'(N_REQ - 1);
            r_gnt        <= '0;
            r_miss       <= '0;
            r_wr_en      <= 1'b0;
            r_frame_tick <= 1'b0;
            r_wr_addr    <= '0;
            r_wr_data    <= '0;
        end else begin
            r_frame_tick <= w_open_edge;
            r_miss       <= w_close_edge ? (bus.req & ~r_gnt) : '0;
            r_gnt        <= w_grant ? w_win : '0;
            r_wr_en      <= w_grant;
            if (w_grant) begin
                r_wr_addr <= w_addr;
                r_wr_data <= w_data;
                r_last    <= w_win_idx;
            end
            if (w_open_edge)
                r_cnt <= '0;
            else if (w_grant)
                r_cnt <= r_cnt + CNT_W'(1);
        end
    end

    assign bus.gnt        = r_gnt;
    assign bus.wr_en      = r_wr_en;
    assign bus.wr_addr    = r_wr_addr;
    assign bus.wr_data    = r_wr_data;
    assign bus.frame_tick = r_frame_tick;
    assign bus.miss       = r_miss;

endmodule
